// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared definitions for the LC-3 memory arbiter: word width, FSM states and port ids.

package lc3_mem_arbiter_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.

module lc3_mem_arbiter_rr_arb2
    import lc3_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_CPU;
        if (&req) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = PORT_LDR;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares single-port LC-3 memory between the core (cpu_*) and the loader (ldr_*),
// one access at a time: grant, one mem_en cycle, fixed latency wait, ack pulse.

module lc3_mem_arbiter
    import lc3_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = WORD_W,
    parameter int unsigned DATA_W  = WORD_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e     state;
    logic [2:0] cnt;
    logic       last_gnt;
    logic       win;
    logic       gnt_valid;
    logic       gnt_id;

    lc3_mem_arbiter_rr_arb2 u_rr_arb2 (
        .req       ({ldr_req, cpu_req & ~boot}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= 3'd0;
            last_gnt  <= PORT_LDR;
            win       <= PORT_CPU;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (gnt_valid) begin
                        win      <= gnt_id;
                        last_gnt <= gnt_id;
                        mem_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StAccess;
                        // mem_we/addr/wdata stay frozen until the next grant
                        if (gnt_id == PORT_LDR) begin
                            mem_we    <= ldr_we;
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                        end else begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                StAccess: begin
                    cnt   <= 3'(MEM_LAT);
                    state <= StWait;
                end
                StWait: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        if (win == PORT_LDR) begin
                            ldr_ack <= 1'b1;
                        end else begin
                            cpu_ack <= 1'b1;
                        end
                        state <= StResp;
                    end
                end
                StResp: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
